mux8_lane_sequencer: RTL and testbench

- Upstream feeder and controller for the 8:1 64-bit lane multiplexer in the accelerator output path.
- Accepts one packed group of up to eight 64-bit words per handshake and holds them in lane registers that drive the mux inputs in_1..in_8.
- Steps the mux select through 0..count-1, one lane per accepted beat, under a valid/ready handshake to the downstream consumer of the mux output.
- Turns a wide parallel result (one PE row) into a 64-bit stream.

---
 rtl/mux8_lane_sequencer.sv | 106 ++++++++++
 tb/tb_mux8_lane_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux8_lane_sequencer.sv
// Feeds an 8:1 lane mux: captures a packed group of lane words and walks the
// mux select across the valid lanes under a valid/ready handshake downstream.
module mux8_lane_sequencer #(
    parameter int DATA_W = 64,
    parameter int LANES  = 8,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W*LANES-1:0] in_data,
    input  logic [3:0]              in_count,
    output logic [DATA_W-1:0]       lane_1,
    output logic [DATA_W-1:0]       lane_2,
    output logic [DATA_W-1:0]       lane_3,
    output logic [DATA_W-1:0]       lane_4,
    output logic [DATA_W-1:0]       lane_5,
    output logic [DATA_W-1:0]       lane_6,
    output logic [DATA_W-1:0]       lane_7,
    output logic [DATA_W-1:0]       lane_8,
    output logic [SEL_W-1:0]        select,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [CNT_W-1:0]        group_cnt,
    output logic                    busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                         state_q, state_d;
    logic [SEL_W-1:0]               sel_q, sel_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [CNT_W-1:0]               grp_q, grp_d;
    logic [LANES-1:0][DATA_W-1:0]   lanes_q, lanes_d;

    logic [3:0] cnt_eff;
    logic       beat;
    logic       last;
    logic       accept;

    // Out-of-range counts (0 or above 8) mean a full group.
    assign cnt_eff   = (in_count == 4'd0 || in_count > 4'd8) ? 4'd8 : in_count;

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign last      = out_valid && (sel_q == SEL_W'(cnt_q - 4'd1));
    assign out_last  = last;
    assign beat      = out_valid & out_ready;
    // Combinational out_ready -> in_ready path lets a new group chain onto the last beat.
    assign in_ready  = (state_q == IDLE) | (beat & last);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        lanes_d = lanes_q;
        if (beat && last) begin
            grp_d   = grp_q + CNT_W'(1);
            state_d = IDLE;
            sel_d   = '0;
        end else if (beat) begin
            sel_d = sel_q + SEL_W'(1);
        end
        if (accept) begin
            state_d = SEND;
            sel_d   = '0;
            cnt_d   = cnt_eff;
            for (int k = 0; k < LANES; k++) begin
                lanes_d[k] = (4'(k) < cnt_eff) ? in_data[k*DATA_W +: DATA_W] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= 4'd8;
            grp_q   <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            lanes_q <= lanes_d;
        end
    end

    assign select    = sel_q;
    assign group_cnt = grp_q;
    assign lane_1    = lanes_q[0];
    assign lane_2    = lanes_q[1];
    assign lane_3    = lanes_q[2];
    assign lane_4    = lanes_q[3];
    assign lane_5    = lanes_q[4];
    assign lane_6    = lanes_q[5];
    assign lane_7    = lanes_q[6];
    assign lane_8    = lanes_q[7];

endmodule

// File: tb/tb_mux8_lane_sequencer.sv
// Directed bench for mux8_lane_sequencer; a second narrow-counter instance covers counter wrap.
module tb_mux8_lane_sequencer;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [511:0] in_data;
    logic [3:0]   in_count, select;
    logic [15:0]  group_cnt;
    logic [63:0]  ln [8];

    logic         w_rst, w_in_valid, w_in_ready, w_out_valid, w_out_last, w_busy;
    logic [3:0]   w_select, w_group_cnt;
    logic [63:0]  wl [8];

    int total = 0;
    int bad   = 0;
    int exp_grp = 0;

    always #5 clk = ~clk;

    mux8_lane_sequencer u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_count(in_count),
        .lane_1(ln[0]), .lane_2(ln[1]), .lane_3(ln[2]), .lane_4(ln[3]),
        .lane_5(ln[4]), .lane_6(ln[5]), .lane_7(ln[6]), .lane_8(ln[7]),
        .select(select), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .group_cnt(group_cnt), .busy(busy)
    );

    mux8_lane_sequencer #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst(w_rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_count(4'd1),
        .lane_1(wl[0]), .lane_2(wl[1]), .lane_3(wl[2]), .lane_4(wl[3]),
        .lane_5(wl[4]), .lane_6(wl[5]), .lane_7(wl[6]), .lane_8(wl[7]),
        .select(w_select), .out_valid(w_out_valid), .out_ready(1'b1),
        .out_last(w_out_last), .group_cnt(w_group_cnt), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [63:0] base);
        for (int k = 0; k < 8; k++) in_data[k*64 +: 64] = base + 64'(k);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_count = 4'd0; in_data = '0;
        w_rst = 1'b1; w_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        for (int k = 0; k < 8; k++) chk("rst_lane", ln[k], 64'd0);
        chk("rst_sel", 64'(select), 64'd0);
        chk("rst_oval", 64'(out_valid), 64'd0);
        chk("rst_olast", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_irdy", 64'(in_ready), 64'd1);
        chk("rst_gcnt", 64'(group_cnt), 64'd0);

        // full group, count 0 -> 8 beats, out_ready held high
        load(64'h10); in_count = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
        chk("full_irdy", 64'(in_ready), 64'd1);
        @(negedge clk); in_valid = 1'b0; in_data = '1;
        for (int k = 0; k < 8; k++) begin
            chk("full_oval", 64'(out_valid), 64'd1);
            chk("full_sel", 64'(select), 64'(k));
            chk("full_last", 64'(out_last), 64'(k == 7));
            chk("full_mux", ln[select[2:0]], 64'h10 + 64'(k));
            @(negedge clk);
        end
        exp_grp = 1;
        chk("full_idle", 64'(out_valid), 64'd0);
        chk("full_busy", 64'(busy), 64'd0);
        chk("full_gcnt", 64'(group_cnt), 64'(exp_grp));
        chk("full_hold", ln[7], 64'h17);

        // partial group (3 lanes) with backpressure
        load(64'hA0); in_count = 4'd3; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        begin
            logic [4:0] rdy;
            int exp_sel [5];
            rdy = 5'b11001;  // bit i = out_ready in step i (1,0,0,1,1)
            exp_sel = '{0, 1, 1, 1, 2};
            for (int i = 0; i < 5; i++) begin
                out_ready = rdy[i];
                chk("part_sel", 64'(select), 64'(exp_sel[i]));
                chk("part_last", 64'(out_last), 64'(exp_sel[i] == 2));
                chk("part_oval", 64'(out_valid), 64'd1);
                chk("part_irdy", 64'(in_ready), 64'(exp_sel[i] == 2 && rdy[i]));
                @(negedge clk);
            end
        end
        exp_grp = 2;
        chk("part_lane3", ln[2], 64'hA2);
        for (int k = 3; k < 8; k++) chk("part_zero", ln[k], 64'd0);
        chk("part_gcnt", 64'(group_cnt), 64'(exp_grp));
        chk("part_idle", 64'(out_valid), 64'd0);

        // back-to-back groups: second offered on the first group's last beat
        out_ready = 1'b1;
        load(64'h20); in_count = 4'd8; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (7) begin
            chk("b2b_oval", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        chk("b2b_sel7", 64'(select), 64'd7);
        load(64'h30); in_valid = 1'b1;
        chk("b2b_irdy", 64'(in_ready), 64'd1);
        @(negedge clk); in_valid = 1'b0;
        chk("b2b_oval0", 64'(out_valid), 64'd1);
        chk("b2b_sel0", 64'(select), 64'd0);
        chk("b2b_lane1", ln[0], 64'h30);
        chk("b2b_gcnt_mid", 64'(group_cnt), 64'd3);
        for (int k = 0; k < 8; k++) begin
            chk("b2b_oval2", 64'(out_valid), 64'd1);
            chk("b2b_mux", ln[select[2:0]], 64'h30 + 64'(k));
            @(negedge clk);
        end
        exp_grp = 4;
        chk("b2b_gcnt", 64'(group_cnt), 64'(exp_grp));

        // single-lane group
        load(64'h55); in_count = 4'd1; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("one_last", 64'(out_last), 64'd1);
        chk("one_sel", 64'(select), 64'd0);
        chk("one_lane1", ln[0], 64'h55);
        chk("one_lane2", ln[1], 64'd0);
        @(negedge clk);
        chk("one_idle", 64'(out_valid), 64'd0);
        chk("one_gcnt", 64'(group_cnt), 64'd5);

        // count 12 behaves as 8
        load(64'h60); in_count = 4'd12; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("c12_last", 64'(out_last), 64'(k == 7));
            @(negedge clk);
        end
        chk("c12_lane8", ln[7], 64'h67);
        chk("c12_gcnt", 64'(group_cnt), 64'd6);

        // reset while at select 4
        load(64'h70); in_count = 4'd8; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mrst_sel4", 64'(select), 64'd4);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mrst_oval", 64'(out_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_sel", 64'(select), 64'd0);
        chk("mrst_lane1", ln[0], 64'd0);
        chk("mrst_gcnt", 64'(group_cnt), 64'd0);

        // counter wrap on the 4-bit instance: 16 chained single-lane groups
        w_rst = 1'b0; w_in_valid = 1'b1;
        @(negedge clk);
        repeat (15) @(negedge clk);
        chk("wrap_max", 64'(w_group_cnt), 64'hF);
        chk("wrap_oval", 64'(w_out_valid), 64'd1);
        w_in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_zero", 64'(w_group_cnt), 64'd0);
        chk("wrap_idle", 64'(w_out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
